// File: rtl/rs_station.sv
// Reservation station: age-ordered compacting array of renamed instructions that
// snoops the CDB for pending operands and dispatches the oldest ready entry.
module rs_station #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       iss_valid,
    output logic                       iss_ready,
    input  logic [OP_W-1:0]            iss_op,
    input  logic [TAG_W-1:0]           iss_dest,
    input  logic [DATA_W-1:0]          iss_vj,
    input  logic [DATA_W-1:0]          iss_vk,
    input  logic [TAG_W-1:0]           iss_qj,
    input  logic [TAG_W-1:0]           iss_qk,
    input  logic                       iss_j_pend,
    input  logic                       iss_k_pend,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [DATA_W-1:0]          cdb_value,
    output logic                       disp_valid,
    input  logic                       disp_ready,
    output logic [OP_W-1:0]            disp_op,
    output logic [DATA_W-1:0]          disp_vj,
    output logic [DATA_W-1:0]          disp_vk,
    output logic [TAG_W-1:0]           disp_dest,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  r_jPend;
    logic [DEPTH-1:0]  r_kPend;
    logic [OP_W-1:0]   r_op   [DEPTH];
    logic [TAG_W-1:0]  r_dest [DEPTH];
    logic [DATA_W-1:0] r_vj   [DEPTH];
    logic [DATA_W-1:0] r_vk   [DEPTH];
    logic [TAG_W-1:0]  r_qj   [DEPTH];
    logic [TAG_W-1:0]  r_qk   [DEPTH];
    logic [CW-1:0]     r_count;

    logic [DEPTH-1:0]  w_ready;
    logic              w_found;
    logic [IW-1:0]     w_sel;
    logic              w_dispFire;
    logic              w_issFire;
    logic [CW-1:0]     w_wrIdx;
    logic [CW-1:0]     w_nCount;
    logic              w_issJPend;
    logic              w_issKPend;
    logic [DATA_W-1:0] w_issVj;
    logic [DATA_W-1:0] w_issVk;

    logic [DEPTH-1:0]  w_nBusy;
    logic [DEPTH-1:0]  w_nJPend;
    logic [DEPTH-1:0]  w_nKPend;
    logic [OP_W-1:0]   w_nOp   [DEPTH];
    logic [TAG_W-1:0]  w_nDest [DEPTH];
    logic [DATA_W-1:0] w_nVj   [DEPTH];
    logic [DATA_W-1:0] w_nVk   [DEPTH];
    logic [TAG_W-1:0]  w_nQj   [DEPTH];
    logic [TAG_W-1:0]  w_nQk   [DEPTH];

    assign w_ready = r_busy & ~r_jPend & ~r_kPend;

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_found = 1'b1;
                w_sel   = IW'(i);
            end
        end
    end

    assign disp_valid = w_found;
    assign disp_op    = w_found ? r_op[w_sel]   : '0;
    assign disp_vj    = w_found ? r_vj[w_sel]   : '0;
    assign disp_vk    = w_found ? r_vk[w_sel]   : '0;
    assign disp_dest  = w_found ? r_dest[w_sel] : '0;

    assign iss_ready  = (r_count < CW'(DEPTH));
    assign count      = r_count;
    assign w_dispFire = w_found && disp_ready && !flush;
    assign w_issFire  = iss_valid && iss_ready && !flush;
    assign w_wrIdx    = w_dispFire ? (r_count - CW'(1)) : r_count;
    assign w_nCount   = r_count + CW'(w_issFire) - CW'(w_dispFire);

    // An operand broadcast during the issue cycle must be caught here or it is lost.
    assign w_issJPend = iss_j_pend && !(cdb_valid && (cdb_tag == iss_qj));
    assign w_issKPend = iss_k_pend && !(cdb_valid && (cdb_tag == iss_qk));
    assign w_issVj    = (iss_j_pend && cdb_valid && (cdb_tag == iss_qj)) ? cdb_value : iss_vj;
    assign w_issVk    = (iss_k_pend && cdb_valid && (cdb_tag == iss_qk)) ? cdb_value : iss_vk;

    // Shift out the dispatched entry, then capture the CDB at post-shift positions, then append.
    always_comb begin
        w_nBusy  = r_busy;
        w_nJPend = r_jPend;
        w_nKPend = r_kPend;
        for (int i = 0; i < DEPTH; i++) begin
            w_nOp[i]   = r_op[i];
            w_nDest[i] = r_dest[i];
            w_nVj[i]   = r_vj[i];
            w_nVk[i]   = r_vk[i];
            w_nQj[i]   = r_qj[i];
            w_nQk[i]   = r_qk[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (w_dispFire && (i >= int'(w_sel))) begin
                w_nBusy[i]  = r_busy[i+1];
                w_nJPend[i] = r_jPend[i+1];
                w_nKPend[i] = r_kPend[i+1];
                w_nOp[i]    = r_op[i+1];
                w_nDest[i]  = r_dest[i+1];
                w_nVj[i]    = r_vj[i+1];
                w_nVk[i]    = r_vk[i+1];
                w_nQj[i]    = r_qj[i+1];
                w_nQk[i]    = r_qk[i+1];
            end
        end
        if (w_dispFire) begin
            w_nBusy[DEPTH-1] = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (cdb_valid && w_nBusy[i] && w_nJPend[i] && (w_nQj[i] == cdb_tag)) begin
                w_nVj[i]    = cdb_value;
                w_nJPend[i] = 1'b0;
            end
            if (cdb_valid && w_nBusy[i] && w_nKPend[i] && (w_nQk[i] == cdb_tag)) begin
                w_nVk[i]    = cdb_value;
                w_nKPend[i] = 1'b0;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_issFire && (i == int'(w_wrIdx))) begin
                w_nBusy[i]  = 1'b1;
                w_nJPend[i] = w_issJPend;
                w_nKPend[i] = w_issKPend;
                w_nOp[i]    = iss_op;
                w_nDest[i]  = iss_dest;
                w_nVj[i]    = w_issVj;
                w_nVk[i]    = w_issVk;
                w_nQj[i]    = iss_qj;
                w_nQk[i]    = iss_qk;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_busy  <= '0;
            r_jPend <= '0;
            r_kPend <= '0;
        end else if (flush) begin
            r_count <= '0;
            r_busy  <= '0;
            r_jPend <= '0;
            r_kPend <= '0;
        end else begin
            r_count <= w_nCount;
            r_busy  <= w_nBusy;
            r_jPend <= w_nJPend;
            r_kPend <= w_nKPend;
        end
    end

    // Payload fields are only meaningful while busy, so they need no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            r_op[i]   <= w_nOp[i];
            r_dest[i] <= w_nDest[i];
            r_vj[i]   <= w_nVj[i];
            r_vk[i]   <= w_nVk[i];
            r_qj[i]   <= w_nQj[i];
            r_qk[i]   <= w_nQk[i];
        end
    end

endmodule
